rate_sched_ctrl: RTL
====================

// Module: rate_sched_ctrl
// PURPOSE
//  Run/stop and rate-selection controller for the board's selectable clock divider.
//  Debounces three pushbuttons (start/stop, faster, slower) and owns the divide counter.
//  Produces a square wave clk_out and a one-cycle tick at each clk_out rising edge.
//  Applies rate changes glitch-free: a new rate takes effect only at a half-period boundary.
//  Feeds the counter and display stages downstream.
// PARAMETERS
//  HALF0       25_000_000  half-period in clk_50mhz cycles, rate index 0 (1 Hz)
//  HALF1        5_000_000  half-period, rate index 1 (5 Hz)
//  HALF2        2_500_000  half-period, rate index 2 (10 Hz)
//  HALF3        1_250_000  half-period, rate index 3 (20 Hz)
//  DEB_CYCLES   1_000_000  stable cycles required to accept a button level (20 ms)
//  CNT_W        32         divide-counter width; every HALFn must be >= 1 and < 2**CNT_W
// PORTS
//  clk_50mhz   in   1  system clock
//  rst         in   1  synchronous reset, active-high
//  btn_run     in   1  raw async pushbutton, active-high; a press toggles run/stop
//  btn_up      in   1  raw async pushbutton; a press requests the next-higher rate index
//  btn_down    in   1  raw async pushbutton; a press requests the next-lower rate index
//  clk_out     out  1  divided square wave; 0 while stopped
//  tick        out  1  one-cycle pulse in the cycle clk_out goes 0->1
//  rate_idx    out  2  rate index currently applied to the divider
//  pend        out  1  1 while a requested rate is waiting for a half-period boundary
//  running     out  1  1 in states RUN and DRAIN
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, cnt=0, clk_out=0, tick=0, rate_idx=0, pend=0,
//   running=0, debouncers cleared to level 0. This holds at any point, including mid-DRAIN.
//  Input path: per button, 2-flop synchroniser, then debouncer. The debouncer accepts a new
//   level after DEB_CYCLES consecutive equal samples. A press = 0->1 of the accepted level,
//   giving one 1-cycle pulse. Press latency = 2 + DEB_CYCLES cycles after the raw edge.
//  Rate request: up press -> req = min(cur+1,3); down press -> req = max(cur-1,0).
//   If up and down presses land in the same cycle, both are ignored. A saturated request
//   (req==cur) is a no-op and does not set pend.
//  half = HALFn selected by rate_idx. Terminal count: cnt >= half-1.
//  States:
//   IDLE : cnt held at 0, clk_out=0. run press -> RUN (cnt starts at 0 next cycle).
//          A rate request is applied to rate_idx immediately; pend stays 0.
//   RUN  : cnt increments each cycle. At terminal count: cnt<=0, clk_out toggles, and
//          tick=1 if clk_out was 0. A rate request -> store req, pend<=1, go to DRAIN.
//   DRAIN: counts as in RUN using the old rate. At terminal count: toggle as in RUN,
//          rate_idx<=req, pend<=0, go to RUN. A further request in DRAIN overwrites req.
//          A request back to the current rate clears pend and returns to RUN.
//   RUN or DRAIN + run press -> IDLE next cycle: clk_out<=0, cnt<=0, tick=0.
//    A pending req is committed to rate_idx and pend<=0.
//  Run press and rate request in the same cycle: the run press is processed first, then the
//   request is handled under the resulting state's rule.
//  A terminal count coinciding with a stop: the stop wins; no toggle and no tick.
//  The clk_out period is 2*half cycles at a steady rate. A half-period is never truncated
//   or extended by a rate change.
// TESTING (bench overrides HALF0=4 HALF1=3 HALF2=2 HALF3=1 DEB_CYCLES=3)
//  1 rst held 2 cycles, then released -> all outputs 0; clk_out stays 0 with no run press.
//  2 btn_run pulsed high 2 cycles -> no press (debounce rejects). Held 6 cycles -> running=1;
//    clk_out period 8 cycles; tick once per period, coinciding with each clk_out 0->1.
//  3 RUN at idx0, btn_up press while cnt=1 -> pend=1, clk_out toggles at cnt=3, then
//    rate_idx=1, pend=0, and the next half-period is exactly 3 cycles.
//  4 Four up presses -> rate_idx=3 (clk_out toggles every cycle). A further up -> no pend,
//    idx stays 3. Down x4 -> idx 0; one more down -> no-op.
//  5 btn_up and btn_down pressed together (same accepted cycle) -> rate_idx, pend unchanged.
//  6 In DRAIN, run press -> IDLE, clk_out=0, rate_idx=req, pend=0. rst asserted in DRAIN ->
//    full reset values next cycle.

Source files
------------

// File: rtl/rate_sched_ctrl.sv
// Run/stop and rate-selection controller for the selectable clock divider.
// Debounces three pushbuttons and owns the divide counter, clk_out and tick.
module rate_sched_ctrl #(
  parameter int unsigned HALF0      = 25_000_000,
  parameter int unsigned HALF1      = 5_000_000,
  parameter int unsigned HALF2      = 2_500_000,
  parameter int unsigned HALF3      = 1_250_000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       clk_out,
  output logic       tick,
  output logic [1:0] rate_idx,
  output logic       pend,
  output logic       running
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Button lanes: bit 0 = run, bit 1 = up, bit 2 = down.
  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       lvl_q;
  logic [2:0]       press_q;
  logic [DEB_W-1:0] deb_cnt_q [3];

  assign btn_raw = {btn_down, btn_up, btn_run};

  // A lane's accepted level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      for (int b = 0; b < 3; b++) begin
        deb_cnt_q[b] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[b] == lvl_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_cnt_q[b] == DEB_LAST) begin
          deb_cnt_q[b] <= '0;
          lvl_q[b]     <= sync2_q[b];
          press_q[b]   <= sync2_q[b];
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + DEB_W'(1);
        end
      end
    end
  end

  function automatic logic [CNT_W-1:0] half_of(input logic [1:0] idx);
    logic [CNT_W-1:0] h;
    case (idx)
      2'd0:    h = CNT_W'(HALF0);
      2'd1:    h = CNT_W'(HALF1);
      2'd2:    h = CNT_W'(HALF2);
      default: h = CNT_W'(HALF3);
    endcase
    return h;
  endfunction

  function automatic logic [1:0] step_rate(input logic [1:0] cur, input logic up);
    logic [1:0] r;
    if (up) begin
      r = (cur == 2'd3) ? 2'd3 : cur + 2'd1;
    end else begin
      r = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [1:0]       rate_q, rate_d;
  logic [1:0]       req_q, req_d;
  logic             pend_q, pend_d;

  logic             run_press;
  logic             rq_valid;
  logic [1:0]       rq;
  logic [CNT_W-1:0] half_m1;
  logic             tc;

  assign run_press = press_q[0];
  // Simultaneous up and down cancel each other.
  assign rq_valid  = press_q[1] ^ press_q[2];
  // The divider always counts against the applied rate; a pending one waits for a boundary.
  assign half_m1   = half_of(rate_q) - CNT_W'(1);
  assign tc        = (cnt_q >= half_m1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    rate_d    = rate_q;
    req_d     = req_q;
    pend_d    = pend_q;
    rq        = 2'd0;

    // Run/stop first; a stop overrides any terminal count in the same cycle.
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (run_press) begin
          state_d = StRun;
        end
      end
      StRun, StDrain: begin
        if (run_press) begin
          state_d   = StIdle;
          cnt_d     = '0;
          clk_out_d = 1'b0;
          if (pend_q) begin
            rate_d = req_q;
          end
          pend_d = 1'b0;
        end else if (tc) begin
          cnt_d     = '0;
          clk_out_d = ~clk_out_q;
          tick_d    = ~clk_out_q;
          if (state_q == StDrain) begin
            rate_d  = req_q;
            pend_d  = 1'b0;
            state_d = StRun;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Rate requests are judged against the state and rate that result from the step above.
    if (rq_valid) begin
      rq = step_rate(rate_d, press_q[1]);
      case (state_d)
        StIdle: begin
          rate_d = rq;
        end
        StRun: begin
          if (rq != rate_d) begin
            req_d   = rq;
            pend_d  = 1'b1;
            state_d = StDrain;
          end
        end
        StDrain: begin
          if (rq != rate_d) begin
            req_d = rq;
          end else begin
            pend_d  = 1'b0;
            state_d = StRun;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      rate_q    <= 2'd0;
      req_q     <= 2'd0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      rate_q    <= rate_d;
      req_q     <= req_d;
      pend_q    <= pend_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign rate_idx = rate_q;
  assign pend     = pend_q;
  assign running  = (state_q != StIdle);

endmodule
